// File: rtl/isa_pkg.sv
// Shared definitions for the ISA instruction issuer.
// Holds the 20-bit instruction word layout, the ALU op codes, the issuer
// FSM state type and a legality test for instruction words.
package isa_pkg;

    // 20-bit instruction word layout:
    // [19:15] A, [14:10] B, [9] reserved, [8:6] ALU sel, [5:1] RAM addr, [0] RAM WE
    localparam int INST_W    = 20;
    localparam int A_LSB     = 15;
    localparam int A_W       = 5;
    localparam int B_LSB     = 10;
    localparam int B_W       = 5;
    localparam int RSV_BIT   = 9;
    localparam int SEL_LSB   = 6;
    localparam int SEL_W     = 3;
    localparam int RADDR_LSB = 1;
    localparam int RADDR_W   = 5;
    localparam int WE_BIT    = 0;

    typedef enum logic [SEL_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_GT  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SETTLE,
        S_CAPTURE,
        S_FIN
    } state_e;

    // A word is legal when the reserved bit is clear and the ALU select
    // names one of the implemented operations.
    function automatic logic is_legal_op(input logic [INST_W-1:0] word);
        logic [SEL_W-1:0] sel;
        sel = word[SEL_LSB +: SEL_W];
        return !word[RSV_BIT] &&
               (sel inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_GT});
    endfunction

endpackage

// File: rtl/isa_settle_timer.sv
// Loadable down-counter used to hold an instruction stable for a fixed
// number of cycles.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - load load_val (has priority over dec)
//   load_val    - value to load
//   dec         - decrement by one (saturates at zero)
//   zero        - counter currently holds zero
module isa_settle_timer
    import isa_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: reset is sampled on the clock edge only; rst_n is not in the
    // sensitivity list, so every flop here and in the top is synchronous-reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/isa_issuer.sv
// Instruction issuer for the ISA datapath.
// Fetches prog_len words from a synchronous instruction memory, presents
// each on `inst` for SETTLE_CYC cycles, then captures `salida` as `result`
// tagged with the instruction's index.
// Optional build macro ISSUER_CHECK_EN: rejects reserved/unimplemented
// words (issued as 0, result forced to all-ones) and adds `err`/`err_cnt`.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   start         - one-cycle pulse, begins a run when idle
//   prog_len      - instruction count, sampled on an accepted start
//   imem_addr     - instruction memory address (data valid one cycle later)
//   imem_data     - instruction memory read data
//   inst          - instruction driven to the ISA datapath
//   salida        - ISA datapath result
//   result        - captured result
//   result_valid  - one-cycle pulse when result/result_idx update
//   result_idx    - index of the captured instruction
//   busy          - high from accepted start until end of run
//   err, err_cnt  - (ISSUER_CHECK_EN only) rejected-slot pulse and count
//   done          - one-cycle end-of-run pulse
module isa_issuer
    import isa_pkg::*;
#(
    parameter int PC_W       = 5,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W:0]     prog_len,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    input  logic [31:0]       salida,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic [PC_W-1:0]   result_idx,
    output logic              busy,
`ifdef ISSUER_CHECK_EN
    output logic              err,
    output logic [PC_W:0]     err_cnt,
`endif
    output logic              done
);

    localparam logic [PC_W:0] MAX_LEN     = {1'b1, {PC_W{1'b0}}};
    localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W:0]       len_q, len_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [31:0]         result_q, result_d;
    logic [PC_W-1:0]     result_idx_q, result_idx_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmr_load, tmr_dec, tmr_zero;
`ifdef ISSUER_CHECK_EN
    logic                bad_q, bad_d;
    logic                err_q, err_d;
    logic [PC_W:0]       err_cnt_q, err_cnt_d;
`endif

    isa_settle_timer #(.CNT_W(4)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // NOTE: every signal gets a default before the case statement so no
    // path leaves a combinational output unassigned (which would infer a latch).
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        len_d          = len_q;
        inst_d         = inst_q;
        result_d       = result_q;
        result_idx_d   = result_idx_q;
        result_valid_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
`ifdef ISSUER_CHECK_EN
        bad_d          = bad_q;
        err_d          = 1'b0;
        err_cnt_d      = err_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                inst_d = '0;
                if (start) begin
`ifdef ISSUER_CHECK_EN
                    err_cnt_d = '0;
`endif
                    if (prog_len != '0) begin
                        // Longer programs saturate so pc never wraps.
                        len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                        pc_d    = '0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                inst_d   = imem_data;
                tmr_load = 1'b1;
                state_d  = S_SETTLE;
`ifdef ISSUER_CHECK_EN
                bad_d = !is_legal_op(imem_data);
                if (!is_legal_op(imem_data)) begin
                    inst_d = '0;
                end
`endif
            end
            S_SETTLE: begin
                // inst_d keeps its default, so inst cannot move mid-settle.
                if (tmr_zero) begin
                    state_d = S_CAPTURE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_CAPTURE: begin
                result_d       = salida;
                result_idx_d   = pc_q;
                result_valid_d = 1'b1;
`ifdef ISSUER_CHECK_EN
                if (bad_q) begin
                    result_d  = 32'hFFFF_FFFF;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_q + 1'b1;
                end
`endif
                if ({1'b0, pc_q} == (len_q - 1'b1)) begin
                    state_d = S_FIN;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                inst_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            len_q          <= '0;
            inst_q         <= '0;
            result_q       <= '0;
            result_idx_q   <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef ISSUER_CHECK_EN
            bad_q          <= 1'b0;
            err_q          <= 1'b0;
            err_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            len_q          <= len_d;
            inst_q         <= inst_d;
            result_q       <= result_d;
            result_idx_q   <= result_idx_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef ISSUER_CHECK_EN
            bad_q          <= bad_d;
            err_q          <= err_d;
            err_cnt_q      <= err_cnt_d;
`endif
        end
    end

    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign result       = result_q;
    assign result_idx   = result_idx_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef ISSUER_CHECK_EN
    assign err          = err_q;
    assign err_cnt      = err_cnt_q;
`endif

endmodule
